// File: rtl/core_pkg.sv
// Shared constants and state encoding for the instruction memory slice.
package core_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/inst_byte_packer.sv
// Packs the loader byte stream little-endian into 32-bit words and raises a
// write strobe on a full word or on an end-of-image strobe with a partial word.
module inst_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [7:0]  load_byte,
  input  logic        done,
  output logic        wr_en,
  output logic [31:0] wr_word
);

  logic [1:0]  byte_idx_r;
  logic [23:0] partial_r;
  logic [31:0] merged_s;
  logic [2:0]  fill_s;

  // Merge the incoming byte into the partial word; bytes not yet seen stay zero
  always_comb begin
    merged_s = {8'h00, partial_r};
    fill_s   = {1'b0, byte_idx_r};
    if (accept) begin
      fill_s = {1'b0, byte_idx_r} + 3'd1;
      case (byte_idx_r)
        2'd0:    merged_s[7:0]   = load_byte;
        2'd1:    merged_s[15:8]  = load_byte;
        2'd2:    merged_s[23:16] = load_byte;
        2'd3:    merged_s[31:24] = load_byte;
        default: merged_s        = {8'h00, partial_r};
      endcase
    end else begin
      fill_s = {1'b0, byte_idx_r};
    end
  end

  assign wr_en   = (fill_s == 3'd4) || (done && (fill_s != 3'd0));
  assign wr_word = merged_s;

  // Byte index and partial word; cleared on reset and after every commit
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_idx_r <= 2'd0;
      partial_r  <= 24'h00_0000;
    end else if (wr_en || done) begin
      byte_idx_r <= 2'd0;
      partial_r  <= 24'h00_0000;
    end else if (accept) begin
      byte_idx_r <= byte_idx_r + 2'd1;
      partial_r  <= merged_s[23:0];
    end
  end

endmodule

// File: rtl/inst_memory.sv
// Instruction memory: byte-stream loader (LOAD) then 1-cycle fetch port (RUN).
// Optional macro INST_MEMORY_FAULT_EN enables misaligned/out-of-range fetch faults.
module inst_memory
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] inst_address,
  input  logic                  inst_csn,
  output logic [DATA_WIDTH-1:0] inst,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_ready,
  input  logic                  load_done,
  output logic                  loaded,
  output logic                  fault
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(NOP_INST);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  mem_state_e            state_r, state_next_s;
  logic [WCW-1:0]        word_count_r, word_count_next_s;
  logic                  load_ready_r, loaded_r, fault_r;
  logic [DATA_WIDTH-1:0] inst_r;
  logic                  accept_s, done_s, wr_en_s;
  logic [31:0]           wr_word_s;
  logic [AW-1:0]         fetch_idx_s;
  logic [DATA_WIDTH-1:0] fetch_word_s;
  logic                  fetch_fault_s;
  logic                  unused_addr_s;

  assign accept_s      = load_valid & load_ready_r;
  assign done_s        = load_done & (state_r == ST_LOAD);
  assign fetch_idx_s   = inst_address[AW+1:2];
  assign unused_addr_s = ^{inst_address[1:0], inst_address[DATA_WIDTH-1:AW+2]};

  inst_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept_s),
    .load_byte (load_byte),
    .done      (done_s),
    .wr_en     (wr_en_s),
    .wr_word   (wr_word_s)
  );

  // Word counter and LOAD->RUN transition (end strobe or array full)
  always_comb begin
    state_next_s      = state_r;
    word_count_next_s = word_count_r;
    case (state_r)
      ST_LOAD: begin
        if (wr_en_s) begin
          word_count_next_s = word_count_r + WCW'(1);
        end else begin
          word_count_next_s = word_count_r;
        end
        if (done_s || (word_count_next_s == WCW'(DEPTH))) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_LOAD;
    endcase
  end

  // Fetch lookup; words beyond the loaded image read back as NOP
  always_comb begin
    fetch_word_s  = NOP_WORD;
    fetch_fault_s = 1'b0;
`ifdef INST_MEMORY_FAULT_EN
    if ((inst_address[1:0] != 2'b00) ||
        (inst_address[DATA_WIDTH-1:AW+2] != {(DATA_WIDTH-AW-2){1'b0}})) begin
      fetch_word_s  = NOP_WORD;
      fetch_fault_s = 1'b1;
    end else if ({1'b0, fetch_idx_s} < word_count_r) begin
      fetch_word_s = mem_r[fetch_idx_s];
    end else begin
      fetch_word_s = NOP_WORD;
    end
`else
    if ({1'b0, fetch_idx_s} < word_count_r) begin
      fetch_word_s = mem_r[fetch_idx_s];
    end else begin
      fetch_word_s = NOP_WORD;
    end
`endif
  end

  // Image write port
  always_ff @(posedge clk) begin
    if (rst && wr_en_s) begin
      mem_r[word_count_r[AW-1:0]] <= DATA_WIDTH'(wr_word_s);
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_LOAD;
      word_count_r <= {WCW{1'b0}};
      load_ready_r <= 1'b1;
      loaded_r     <= 1'b0;
      fault_r      <= 1'b0;
      inst_r       <= NOP_WORD;
    end else begin
      state_r      <= state_next_s;
      word_count_r <= word_count_next_s;
      load_ready_r <= (state_next_s == ST_LOAD) && (word_count_next_s < WCW'(DEPTH));
      loaded_r     <= (state_next_s == ST_RUN);
      if ((state_r == ST_RUN) && !inst_csn) begin
        inst_r  <= fetch_word_s;
        fault_r <= fault_r | fetch_fault_s;
      end
    end
  end

  assign inst       = inst_r;
  assign load_ready = load_ready_r;
  assign loaded     = loaded_r;
  assign fault      = fault_r;

endmodule

// File: tb/tb_inst_memory.sv
// Self-checking bench for inst_memory: loader sequences plus a fetch scoreboard.
module tb_inst_memory;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_address = 32'h0;
  logic        inst_csn = 1'b1;
  logic [31:0] inst;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_ready;
  logic        load_done = 1'b0;
  logic        loaded;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  fetch_vec_t  vecs[8];
  logic [31:0] exp_q[$];

  inst_memory #(.DATA_WIDTH(32), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .inst_address(inst_address), .inst_csn(inst_csn),
    .inst(inst), .load_valid(load_valid), .load_byte(load_byte),
    .load_ready(load_ready), .load_done(load_done), .loaded(loaded), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic d);
    load_valid = 1'b1;
    load_byte  = b;
    load_done  = d;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] e, input string name);
    inst_csn     = 1'b0;
    inst_address = a;
    exp_q.push_back(e);
    tick();
    inst_csn = 1'b1;
    check(name, inst, exp_q.pop_front());
  endtask

  initial begin
    vecs[0] = '{32'h0000_0004, 32'h0010_0093};
    vecs[1] = '{32'h0000_0000, 32'h0000_0013};
    vecs[2] = '{32'h0000_0008, 32'h1234_5678};
    vecs[3] = '{32'h0000_000C, 32'h0000_CDAB};
    vecs[4] = '{32'h0000_0010, NOP};
    vecs[5] = '{32'h0000_0040, NOP};
    vecs[6] = '{32'h0000_0004, 32'h0010_0093};
    vecs[7] = '{32'h0000_000C, 32'h0000_CDAB};

    tick();
    do_reset();
    check("reset_inst", inst, NOP);
    check("reset_loaded", {31'b0, loaded}, 32'd0);
    check("reset_fault", {31'b0, fault}, 32'd0);
    check("reset_load_ready", {31'b0, load_ready}, 32'd1);

    // Load 3 full words and a 2-byte tail with load_done on the last byte,
    // while a fetch is requested the whole time (must be ignored in LOAD).
    inst_csn     = 1'b0;
    inst_address = 32'h0;
    send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    send(8'h93, 1'b0); send(8'h00, 1'b0); send(8'h10, 1'b0); send(8'h00, 1'b0);
    send(8'h78, 1'b0); send(8'h56, 1'b0); send(8'h34, 1'b0);
    check("mid_load_ready", {31'b0, load_ready}, 32'd1);
    check("mid_load_loaded", {31'b0, loaded}, 32'd0);
    send(8'h12, 1'b0);
    send(8'hAB, 1'b0); send(8'hCD, 1'b1);
    inst_csn = 1'b1;
    check("fetch_in_load_held", inst, NOP);
    check("run_loaded", {31'b0, loaded}, 32'd1);
    check("run_load_ready", {31'b0, load_ready}, 32'd0);

    // Back-to-back fetches through the scoreboard
    inst_csn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      inst_address = vecs[i].addr;
      exp_q.push_back(vecs[i].exp);
      tick();
      check($sformatf("fetch_vec%0d", i), inst, exp_q.pop_front());
    end
    inst_csn = 1'b1;
    check("table_fault", {31'b0, fault}, 32'd0);

    inst_address = 32'h0000_0008;
    tick();
    check("csn_hold", inst, 32'h0000_CDAB);
    load_valid = 1'b1;
    load_byte  = 8'h55;
    tick();
    load_valid = 1'b0;
    check("run_ignores_bytes", {31'b0, load_ready}, 32'd0);
    fetch(32'h0000_0010, NOP, "run_bytes_not_stored");

`ifdef INST_MEMORY_FAULT_EN
    fetch(32'h0000_0002, NOP, "misaligned_nop");
    check("misaligned_fault", {31'b0, fault}, 32'd1);
    fetch(32'h0000_0004, 32'h0010_0093, "legal_after_fault");
    check("fault_sticky", {31'b0, fault}, 32'd1);
    fetch(32'h0000_0408, NOP, "out_of_range_nop");
`else
    fetch(32'h0000_0002, NOP, "low_bits_ignored_w0");
    fetch(32'h0000_0009, 32'h1234_5678, "low_bits_ignored_w2");
    fetch(32'h0000_0408, 32'h1234_5678, "index_wraps");
    check("no_fault", {31'b0, fault}, 32'd0);
`endif

    // Five bytes, load_done with the fifth
    do_reset();
    check("reset2_inst", inst, NOP);
    check("reset2_fault", {31'b0, fault}, 32'd0);
    check("reset2_loaded", {31'b0, loaded}, 32'd0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    send(8'h05, 1'b1);
    fetch(32'h0000_0004, 32'h0000_0005, "partial_word");
    fetch(32'h0000_0000, 32'h0403_0201, "le_pack");
    fetch(32'h0000_0008, NOP, "word_count_2");

    // Reset mid-load, reload one word, load_done on its own cycle
    do_reset();
    for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), 1'b0);
    do_reset();
    send(8'hEF, 1'b0); send(8'hBE, 1'b0); send(8'hAD, 1'b0); send(8'hDE, 1'b0);
    check("reload_not_run", {31'b0, loaded}, 32'd0);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("done_alone_loaded", {31'b0, loaded}, 32'd1);
    fetch(32'h0000_0000, 32'hDEAD_BEEF, "reload_word0");
    fetch(32'h0000_0004, NOP, "stale_word1_hidden");

    // Fill the whole array without load_done
    do_reset();
    for (int i = 0; i < 1023; i++) send(8'(i), 1'b0);
    check("full_last_ready", {31'b0, load_ready}, 32'd1);
    send(8'hFF, 1'b0);
    check("full_ready_drop", {31'b0, load_ready}, 32'd0);
    send(8'hAA, 1'b0);
    tick();
    check("full_loaded", {31'b0, loaded}, 32'd1);
    fetch(32'h0000_03FC, 32'hFFFE_FDFC, "full_last_word");
    fetch(32'h0000_0000, 32'h0302_0100, "full_first_word");
`ifdef INST_MEMORY_FAULT_EN
    fetch(32'h0000_0400, NOP, "full_oob_nop");
    check("full_oob_fault", {31'b0, fault}, 32'd1);
`else
    fetch(32'h0000_0400, 32'h0302_0100, "full_wrap");
    check("full_no_fault", {31'b0, fault}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
